// File: rtl/vco_meas_pkg.sv
// vco_meas_pkg: shared types and defaults for the VCO frequency counter.
// Holds the FSM state enum, source-select codes and default widths.
package vco_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } meas_state_t;

  localparam logic DIV_SEL_128 = 1'b0;
  localparam logic DIV_SEL_256 = 1'b1;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int DEF_GATE_W      = 16;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/vco_edge_sync.sv
// vco_edge_sync: multi-flop synchroniser plus rise detector.
// Ports: clk, rst_n, async_in -> rise (one-cycle pulse on a 0->1 level).
module vco_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vco_freq_counter.sv
// vco_freq_counter: counts rising edges of a divided VCO over a gate window.
// Ports: wb_clk_i, wb_rst_n, vco_div128/256, div_sel, start, cont,
//        gate_cycles -> count, count_valid, overflow, busy.
module vco_freq_counter
  import vco_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              vco_div128,
  input  logic              vco_div256,
  input  logic              div_sel,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              overflow,
  output logic              busy
);

  // Illegal depths are clamped up to the safe minimum.
  localparam int SYNC_N =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int SET_W = $clog2(SYNC_N + 2);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SYNC_N);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  meas_state_t       state;
  logic              src_q;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] win_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat_q;

  logic              rise128;
  logic              rise256;
  logic              sel_rise;
  logic [GATE_W-1:0] gate_eff;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              sat_nxt;

  vco_edge_sync #(
    .SYNC_STAGES(SYNC_N)
  ) u_sync128 (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .async_in(vco_div128),
    .rise    (rise128)
  );

  vco_edge_sync #(
    .SYNC_STAGES(SYNC_N)
  ) u_sync256 (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .async_in(vco_div256),
    .rise    (rise256)
  );

  // Mux after both synchronisers so a div_sel change cannot glitch.
  assign sel_rise =
    (src_q == DIV_SEL_256) ? rise256 : rise128;

  assign gate_eff =
    (gate_cycles == '0) ? GATE_ONE : gate_cycles;

  // Saturating increment; sat marks a rise lost at full scale.
  always_comb begin
    cnt_nxt = edge_cnt;
    sat_nxt = sat_q;
    if (sel_rise) begin
      if (edge_cnt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        cnt_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      src_q       <= DIV_SEL_128;
      gate_q      <= GATE_ONE;
      win_cnt     <= '0;
      settle_cnt  <= '0;
      edge_cnt    <= '0;
      sat_q       <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_q      <= div_sel;
            gate_q     <= gate_eff;
            win_cnt    <= gate_eff;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Rises are ignored while the sync pipe flushes.
          if (settle_cnt == SET_LAST) begin
            state <= COUNT;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        COUNT: begin
          edge_cnt <= cnt_nxt;
          sat_q    <= sat_nxt;
          win_cnt  <= win_cnt - GATE_ONE;
          // Publish on entry to DONE so the last cycle is included.
          if (win_cnt == GATE_ONE) begin
            count       <= cnt_nxt;
            overflow    <= sat_nxt;
            count_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (cont) begin
            edge_cnt <= '0;
            sat_q    <= 1'b0;
            win_cnt  <= gate_q;
            state    <= COUNT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vco_freq_counter.sv
// tb_vco_freq_counter: directed bench with a timestamp-based window model.
// Drives both DUT widths (16 and 4 bit counters) from shared stimulus.
module tb_vco_freq_counter;

  localparam int S    = 2;
  localparam int TCLK = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vco128 = 1'b0;
  logic        vco256 = 1'b0;
  logic        div_sel;
  logic        start;
  logic        cont;
  logic [15:0] gate_cycles;
  logic [15:0] cnt16;
  logic        cv16, ovf16, busy16;
  logic [3:0]  cnt4;
  logic        cv4, ovf4, busy4;

  bit en128 = 1'b0;
  bit en256 = 1'b0;
  longint q128[$];
  longint q256[$];

  int checks = 0;
  int errors = 0;

  vco_freq_counter #(.SYNC_STAGES(S)) dut16 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .vco_div128(vco128), .vco_div256(vco256),
    .div_sel(div_sel), .start(start), .cont(cont),
    .gate_cycles(gate_cycles),
    .count(cnt16), .count_valid(cv16),
    .overflow(ovf16), .busy(busy16)
  );

  vco_freq_counter #(.SYNC_STAGES(S), .CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .vco_div128(vco128), .vco_div256(vco256),
    .div_sel(div_sel), .start(start), .cont(cont),
    .gate_cycles(gate_cycles),
    .count(cnt4), .count_valid(cv4),
    .overflow(ovf4), .busy(busy4)
  );

  always #(TCLK/2) clk = ~clk;

  // 40-unit and 80-unit periods, edges offset from clock edges.
  initial begin
    #2;
    forever begin
      if (en128) begin
        vco128 = ~vco128;
        if (vco128) q128.push_back(longint'($time));
      end
      #20;
    end
  end

  initial begin
    #6;
    forever begin
      if (en256) begin
        vco256 = ~vco256;
        if (vco256) q256.push_back(longint'($time));
      end
      #40;
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  function automatic int count_in(bit src, longint t0,
                                  longint t1);
    int n = 0;
    if (src) begin
      foreach (q256[i])
        if (q256[i] > t0 && q256[i] < t1) n++;
    end else begin
      foreach (q128[i])
        if (q128[i] > t0 && q128[i] < t1) n++;
    end
    return n;
  endfunction

  // Model: an accepted start fixes the result edge; the counted
  // source edges are those inside the window seen through S flops.
  int   cyc = 0;
  bit   m_act = 1'b0;
  bit   m_done = 1'b0;
  int   m_res = 0;
  int   m_gate = 1;
  bit   m_src = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;
  logic [15:0] exp_cnt16 = '0;
  logic        exp_ovf16 = 1'b0;
  logic [3:0]  exp_cnt4 = '0;
  logic        exp_ovf4 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_done = 1'b0;
      exp_valid = 1'b0;
      exp_busy = 1'b0;
      exp_cnt16 = '0;
      exp_ovf16 = 1'b0;
      exp_cnt4 = '0;
      exp_ovf4 = 1'b0;
    end else begin
      cyc++;
      if (m_done) begin
        m_done = 1'b0;
        exp_valid = 1'b0;
        if (cont) begin
          m_res = cyc + m_gate;
        end else begin
          m_act = 1'b0;
          exp_busy = 1'b0;
        end
      end else if (m_act && cyc == m_res) begin
        longint tn;
        int n;
        tn = longint'($time);
        n = count_in(m_src,
                     tn - longint'((S + m_gate) * TCLK),
                     tn - longint'(S * TCLK));
        exp_valid = 1'b1;
        exp_cnt16 = (n > 65535) ? 16'hFFFF : 16'(n);
        exp_ovf16 = (n > 65535);
        exp_cnt4  = (n > 15) ? 4'hF : 4'(n);
        exp_ovf4  = (n > 15);
        m_done = 1'b1;
      end else if (!m_act && start) begin
        m_act = 1'b1;
        m_gate = (gate_cycles == 16'd0) ? 1 : int'(gate_cycles);
        m_src = div_sel;
        m_res = cyc + S + 1 + m_gate;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cv16", 32'(cv16), 32'(exp_valid));
    chk("busy16", 32'(busy16), 32'(exp_busy));
    chk("cnt16", 32'(cnt16), 32'(exp_cnt16));
    chk("ovf16", 32'(ovf16), 32'(exp_ovf16));
    chk("cv4", 32'(cv4), 32'(exp_valid));
    chk("busy4", 32'(busy4), 32'(exp_busy));
    chk("cnt4", 32'(cnt4), 32'(exp_cnt4));
    chk("ovf4", 32'(ovf4), 32'(exp_ovf4));
  end

  task automatic do_start(bit sel, int g, bit c);
    @(negedge clk);
    div_sel = sel;
    gate_cycles = 16'(g);
    cont = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n = index of the negedge (after the call) where cv16 is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cv16 && n < 2000);
    if (!cv16) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got timeout, expected count_valid");
    end
  endtask

  task automatic no_valid(string name, int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cv16) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    div_sel = 1'b0;
    gate_cycles = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_count", 32'(cnt16), 32'd0);
    chk("rst_valid", 32'(cv16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_ovf", 32'(ovf16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_start(1'b1, 20, 1'b0);
    wait_valid(n);
    chk("static_lat", 32'(n), 32'(S + 2 + 20));
    chk("static_cnt", 32'(cnt16), 32'd0);

    en128 = 1'b1;
    en256 = 1'b1;
    repeat (10) @(negedge clk);

    do_start(1'b1, 800, 1'b0);
    chk("single_busy_early", 32'(busy16), 32'd1);
    wait_valid(n);
    chk("single_lat", 32'(n), 32'(S + 2 + 800));
    chk_rng("single_cnt", int'(cnt16), 99, 101);
    chk("single_ovf", 32'(ovf16), 32'd0);
    chk("single_busy_done", 32'(busy16), 32'd1);
    @(negedge clk);
    chk("single_busy_after", 32'(busy16), 32'd0);

    do_start(1'b0, 400, 1'b0);
    wait_valid(n);
    chk_rng("sel128_cnt", int'(cnt16), 99, 101);

    do_start(1'b1, 400, 1'b0);
    repeat (100) @(negedge clk);
    div_sel = 1'b0;
    wait_valid(n);
    chk_rng("sel256_toggle_cnt", int'(cnt16), 49, 51);

    do_start(1'b0, 200, 1'b0);
    wait_valid(n);
    chk("sat_cnt4", 32'(cnt4), 32'd15);
    chk("sat_ovf4", 32'(ovf4), 32'd1);
    chk_rng("sat_cnt16", int'(cnt16), 49, 51);
    do_start(1'b0, 20, 1'b0);
    wait_valid(n);
    chk_rng("unsat_cnt4", int'(cnt4), 4, 6);
    chk("unsat_ovf4", 32'(ovf4), 32'd0);

    do_start(1'b1, 80, 1'b1);
    wait_valid(n);
    chk("cont_lat0", 32'(n), 32'(S + 2 + 80));
    chk_rng("cont_cnt0", int'(cnt16), 9, 11);
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      chk("cont_period", 32'(n), 32'd81);
      chk_rng("cont_cnt", int'(cnt16), 9, 11);
    end
    repeat (10) @(negedge clk);
    cont = 1'b0;
    wait_valid(n);
    chk("cont_last_period", 32'(n), 32'd71);
    chk_rng("cont_last_cnt", int'(cnt16), 9, 11);
    @(negedge clk);
    chk("cont_busy_after", 32'(busy16), 32'd0);
    no_valid("cont_no_more", 100);

    do_start(1'b0, 0, 1'b0);
    wait_valid(n);
    chk("gate0_lat", 32'(n), 32'(S + 3));

    do_start(1'b1, 50, 1'b0);
    repeat (20) @(negedge clk);
    gate_cycles = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    chk("busy_start_lat", 32'(n), 32'(S + 2 + 50 - 21));
    no_valid("busy_start_once", 100);

    do_start(1'b1, 800, 1'b0);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(cnt16), 32'd0);
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_valid", 32'(cv16), 32'd0);
    chk("midrst_ovf", 32'(ovf16), 32'd0);
    chk("midrst_busy4", 32'(busy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid("midrst_no_result", 900);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
